// File: rtl/hpu_task_frontend.sv
// HPU task frontend: latches one scheduler task, hands it to the core, and returns feedback on completion.
// Optional watchdog build (HPU_FRONTEND_WATCHDOG_EN) forces completion of tasks stuck in Running.

package hpu_frontend_pkg;

    typedef struct packed {
        logic [7:0]  handler_id;
        logic [31:0] msg_addr;
        logic [15:0] pkt_len;
    } handler_task_t;

    typedef struct packed {
        logic [31:0]   pkt_ptr;
        handler_task_t handler_task;
    } hpu_handler_task_t;

    // Field order differs from handler_task_t, so feedback must be built field by field.
    typedef struct packed {
        logic [15:0] pkt_len;
        logic [31:0] msg_addr;
        logic [7:0]  handler_id;
    } feedback_descr_t;

    typedef struct packed {
        logic [31:0]     pkt_ptr;
        feedback_descr_t feedback_descr;
    } task_feedback_descr_t;

endpackage

module hpu_task_frontend
    import hpu_frontend_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 4096,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hpu_task_valid_i,
    output logic                  hpu_task_ready_o,
    input  hpu_handler_task_t     hpu_task_i,
    output logic                  core_task_valid_o,
    input  logic                  core_task_ready_i,
    output hpu_handler_task_t     core_task_o,
    input  logic                  core_done_i,
    output logic                  hpu_feedback_valid_o,
    input  logic                  hpu_feedback_ready_i,
    output task_feedback_descr_t  hpu_feedback_o,
    output logic                  hpu_active_o,
    output logic [CNT_WIDTH-1:0]  tasks_done_o,
    output logic                  wd_timeout_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPATCH = 2'd1,
        RUNNING  = 2'd2,
        FEEDBACK = 2'd3
    } state_e;

    if (WATCHDOG_CYCLES < 1) begin : g_wd_cfg_check
        $error("WATCHDOG_CYCLES must be at least 1");
    end

    state_e                state_q;
    hpu_handler_task_t     task_q;
    logic [CNT_WIDTH-1:0]  done_cnt_q;

`ifdef HPU_FRONTEND_WATCHDOG_EN
    localparam int unsigned WD_W = (WATCHDOG_CYCLES > 1) ? $clog2(WATCHDOG_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q;
    logic            wd_q;

    // Completion from the core wins over the watchdog in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            task_q     <= '0;
            done_cnt_q <= '0;
            wd_cnt_q   <= '0;
            wd_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hpu_task_valid_i) begin
                        task_q  <= hpu_task_i;
                        state_q <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (core_task_ready_i) begin
                        state_q  <= RUNNING;
                        wd_cnt_q <= '0;
                    end
                end
                RUNNING: begin
                    if (core_done_i) begin
                        state_q <= FEEDBACK;
                    end else if (wd_cnt_q == WD_LAST) begin
                        state_q <= FEEDBACK;
                        wd_q    <= 1'b1;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                FEEDBACK: begin
                    if (hpu_feedback_ready_i) begin
                        state_q    <= IDLE;
                        done_cnt_q <= done_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wd_timeout_o = wd_q;
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            task_q     <= '0;
            done_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hpu_task_valid_i) begin
                        task_q  <= hpu_task_i;
                        state_q <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (core_task_ready_i) begin
                        state_q <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (core_done_i) begin
                        state_q <= FEEDBACK;
                    end
                end
                FEEDBACK: begin
                    if (hpu_feedback_ready_i) begin
                        state_q    <= IDLE;
                        done_cnt_q <= done_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wd_timeout_o = 1'b0;
`endif

    assign hpu_task_ready_o     = (state_q == IDLE);
    assign core_task_valid_o    = (state_q == DISPATCH);
    assign hpu_feedback_valid_o = (state_q == FEEDBACK);
    assign hpu_active_o         = (state_q != IDLE);
    assign tasks_done_o         = done_cnt_q;
    assign core_task_o          = task_q;

    assign hpu_feedback_o.pkt_ptr                   = task_q.pkt_ptr;
    assign hpu_feedback_o.feedback_descr.pkt_len    = task_q.handler_task.pkt_len;
    assign hpu_feedback_o.feedback_descr.msg_addr   = task_q.handler_task.msg_addr;
    assign hpu_feedback_o.feedback_descr.handler_id = task_q.handler_task.handler_id;

endmodule

// File: tb/tb_hpu_task_frontend.sv
// Self-checking bench for hpu_task_frontend: table-driven cycle vectors plus hand-written reset sequences.
// Instance A uses default parameters; instance B uses CNT_WIDTH=2, WATCHDOG_CYCLES=8.

module tb_hpu_task_frontend;
    import hpu_frontend_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              valid;
        hpu_handler_task_t taskDesc;
        logic              coreReady;
        logic              coreDone;
        logic              fbReady;
    } stim_t;

    typedef enum int {PH_IDLE, PH_DISP, PH_RUN, PH_FB} phase_e;

    typedef struct {
        string             name;
        bit                sel;
        stim_t             s;
        phase_e            expPhase;
        logic [15:0]       expDone;
        logic              expWd;
        hpu_handler_task_t expTask;
    } vec_t;

    stim_t stimA = '0;
    stim_t stimB = '0;
    logic  rstA  = 1'b1;
    logic  rstB  = 1'b1;

    logic                 readyA, coreValidA, fbValidA, activeA, wdA;
    hpu_handler_task_t    coreTaskA;
    task_feedback_descr_t fbA;
    logic [15:0]          doneA;

    logic                 readyB, coreValidB, fbValidB, activeB, wdB;
    hpu_handler_task_t    coreTaskB;
    task_feedback_descr_t fbB;
    logic [1:0]           doneB;

    hpu_task_frontend #(.WATCHDOG_CYCLES(4096), .CNT_WIDTH(16)) dutA (
        .clk_i(clk), .rst_i(rstA),
        .hpu_task_valid_i(stimA.valid), .hpu_task_ready_o(readyA), .hpu_task_i(stimA.taskDesc),
        .core_task_valid_o(coreValidA), .core_task_ready_i(stimA.coreReady), .core_task_o(coreTaskA),
        .core_done_i(stimA.coreDone),
        .hpu_feedback_valid_o(fbValidA), .hpu_feedback_ready_i(stimA.fbReady), .hpu_feedback_o(fbA),
        .hpu_active_o(activeA), .tasks_done_o(doneA), .wd_timeout_o(wdA)
    );

    hpu_task_frontend #(.WATCHDOG_CYCLES(8), .CNT_WIDTH(2)) dutB (
        .clk_i(clk), .rst_i(rstB),
        .hpu_task_valid_i(stimB.valid), .hpu_task_ready_o(readyB), .hpu_task_i(stimB.taskDesc),
        .core_task_valid_o(coreValidB), .core_task_ready_i(stimB.coreReady), .core_task_o(coreTaskB),
        .core_done_i(stimB.coreDone),
        .hpu_feedback_valid_o(fbValidB), .hpu_feedback_ready_i(stimB.fbReady), .hpu_feedback_o(fbB),
        .hpu_active_o(activeB), .tasks_done_o(doneB), .wd_timeout_o(wdB)
    );

    int passCount  = 0;
    int checkCount = 0;
    vec_t vecs[$];
    hpu_handler_task_t t0, t1, t2, t3, t4, zeroTask;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic task_feedback_descr_t toFeedback(input hpu_handler_task_t t);
        task_feedback_descr_t r;
        r.pkt_ptr                   = t.pkt_ptr;
        r.feedback_descr.pkt_len    = t.handler_task.pkt_len;
        r.feedback_descr.msg_addr   = t.handler_task.msg_addr;
        r.feedback_descr.handler_id = t.handler_task.handler_id;
        return r;
    endfunction

    function automatic hpu_handler_task_t mkTask(input logic [31:0] ptr, input logic [7:0] id,
                                                 input logic [31:0] addr, input logic [15:0] len);
        hpu_handler_task_t t;
        t.pkt_ptr                 = ptr;
        t.handler_task.handler_id = id;
        t.handler_task.msg_addr   = addr;
        t.handler_task.pkt_len    = len;
        return t;
    endfunction

    function automatic void addRow(input string name, input bit sel, input bit v, input hpu_handler_task_t t,
                                   input bit cr, input bit cd, input bit fr, input phase_e ph,
                                   input int done, input bit wd, input hpu_handler_task_t expT);
        vec_t r;
        r.name       = name;
        r.sel        = sel;
        r.s.valid    = v;
        r.s.taskDesc = t;
        r.s.coreReady = cr;
        r.s.coreDone = cd;
        r.s.fbReady  = fr;
        r.expPhase   = ph;
        r.expDone    = 16'(done);
        r.expWd      = wd;
        r.expTask    = expT;
        vecs.push_back(r);
    endfunction

    task automatic applyStimulus(input bit sel, input stim_t s);
        stimA = sel ? '0 : s;
        stimB = sel ? s : '0;
    endtask

    task automatic checkRow(input vec_t v, input int idx);
        logic [3:0]           flags;
        logic [3:0]           expFlags;
        logic [15:0]          done;
        logic                 wd;
        hpu_handler_task_t    ct;
        task_feedback_descr_t fb;
        if (v.sel) begin
            flags = {readyB, coreValidB, fbValidB, activeB};
            done  = {14'd0, doneB};
            wd    = wdB;
            ct    = coreTaskB;
            fb    = fbB;
        end else begin
            flags = {readyA, coreValidA, fbValidA, activeA};
            done  = doneA;
            wd    = wdA;
            ct    = coreTaskA;
            fb    = fbA;
        end
        expFlags = {v.expPhase == PH_IDLE, v.expPhase == PH_DISP, v.expPhase == PH_FB, v.expPhase != PH_IDLE};
        checkOutput($sformatf("%s[%0d] rdy/cval/fval/active", v.name, idx), 128'(flags), 128'(expFlags));
        checkOutput($sformatf("%s[%0d] tasks_done", v.name, idx), 128'(done), 128'(v.expDone));
        checkOutput($sformatf("%s[%0d] wd_timeout", v.name, idx), 128'(wd), 128'(v.expWd));
        if (v.expPhase == PH_DISP)
            checkOutput($sformatf("%s[%0d] core_task", v.name, idx), 128'(ct), 128'(v.expTask));
        if (v.expPhase == PH_FB)
            checkOutput($sformatf("%s[%0d] feedback", v.name, idx), 128'(fb), 128'(toFeedback(v.expTask)));
    endtask

    task automatic runTable();
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].sel, vecs[i].s);
            @(posedge clk);
            #1;
            checkRow(vecs[i], i);
        end
        applyStimulus(1'b0, '0);
        vecs.delete();
    endtask

    task automatic resetB();
        rstB = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resetB tasks_done", 128'(doneB), 128'(0));
        checkOutput("resetB wd_timeout", 128'(wdB), 128'(0));
        rstB = 1'b0;
    endtask

    initial begin
        zeroTask = '0;
        t0 = mkTask(32'h1000_0040, 8'h11, 32'hA000_0100, 16'd64);
        t1 = mkTask(32'h2000_0080, 8'h22, 32'hB000_0200, 16'd128);
        t2 = mkTask(32'h3000_00C0, 8'h33, 32'hC000_0300, 16'd1500);
        t3 = mkTask(32'h4000_0100, 8'h44, 32'hD000_0400, 16'd9);
        t4 = mkTask(32'h5000_0140, 8'h55, 32'hE000_0500, 16'd256);

        @(posedge clk);
        #1;
        checkOutput("reset A flags", 128'({readyA, coreValidA, fbValidA, activeA}), 128'(4'b1000));
        checkOutput("reset A count/wd", 128'({doneA, wdA}), 128'(0));
        checkOutput("reset A core_task", 128'(coreTaskA), 128'(0));
        checkOutput("reset B flags", 128'({readyB, coreValidB, fbValidB, activeB}), 128'(4'b1000));
        rstA = 1'b0;
        rstB = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready after reset A", 128'(readyA), 128'(1));
        checkOutput("ready after reset B", 128'(readyB), 128'(1));

        // Basic flow, no-accept-on-Feedback-exit, backpressure and stray done pulses on instance A.
        addRow("basic", 0, 1, t0, 0, 0, 0, PH_DISP, 0, 0, t0);
        addRow("basic", 0, 0, t0, 1, 0, 0, PH_RUN, 0, 0, t0);
        for (int i = 0; i < 9; i++) addRow("basic", 0, 0, t0, 0, 0, 0, PH_RUN, 0, 0, t0);
        addRow("basic", 0, 0, t0, 0, 1, 0, PH_FB, 0, 0, t0);
        addRow("basic", 0, 1, t1, 0, 0, 1, PH_IDLE, 1, 0, t0);
        addRow("spacing", 0, 1, t1, 0, 0, 0, PH_DISP, 1, 0, t1);
        for (int i = 0; i < 5; i++) addRow("bpCore", 0, 1, t2, 0, 0, 0, PH_DISP, 1, 0, t1);
        addRow("bpCore", 0, 0, t2, 1, 0, 0, PH_RUN, 1, 0, t1);
        addRow("bpCore", 0, 0, t2, 0, 1, 0, PH_FB, 1, 0, t1);
        for (int i = 0; i < 7; i++) addRow("bpFb", 0, 1, t2, 0, 1, 0, PH_FB, 1, 0, t1);
        addRow("bpFb", 0, 0, t2, 0, 0, 1, PH_IDLE, 2, 0, t1);
        addRow("stray", 0, 0, t2, 0, 1, 0, PH_IDLE, 2, 0, t1);
        addRow("stray", 0, 1, t2, 0, 0, 0, PH_DISP, 2, 0, t2);
        addRow("stray", 0, 0, t2, 1, 1, 0, PH_RUN, 2, 0, t2);
        for (int i = 0; i < 3; i++) addRow("stray", 0, 0, t2, 0, 0, 0, PH_RUN, 2, 0, t2);
        addRow("stray", 0, 0, t2, 0, 1, 0, PH_FB, 2, 0, t2);
        addRow("stray", 0, 0, t2, 0, 0, 1, PH_IDLE, 3, 0, t2);
        runTable();

        // Asynchronous reset while Running: task is dropped with no feedback.
        applyStimulus(0, '{valid: 1'b1, taskDesc: t0, coreReady: 1'b0, coreDone: 1'b0, fbReady: 1'b0});
        @(posedge clk);
        #1;
        applyStimulus(0, '{valid: 1'b0, taskDesc: t0, coreReady: 1'b1, coreDone: 1'b0, fbReady: 1'b0});
        @(posedge clk);
        #1;
        applyStimulus(0, '0);
        checkOutput("midReset in Running", 128'({coreValidA, fbValidA, activeA}), 128'(3'b001));
        #2;
        rstA = 1'b1;
        #1;
        checkOutput("midReset valids", 128'({coreValidA, fbValidA, activeA}), 128'(0));
        checkOutput("midReset tasks_done", 128'(doneA), 128'(0));
        checkOutput("midReset core_task", 128'(coreTaskA), 128'(zeroTask));
        @(posedge clk);
        #1;
        rstA = 1'b0;
        applyStimulus(0, '{valid: 1'b0, taskDesc: t0, coreReady: 1'b0, coreDone: 1'b1, fbReady: 1'b1});
        @(posedge clk);
        #1;
        applyStimulus(0, '0);
        checkOutput("postReset flags", 128'({readyA, coreValidA, fbValidA, activeA}), 128'(4'b1000));
        checkOutput("postReset tasks_done", 128'(doneA), 128'(0));

`ifdef HPU_FRONTEND_WATCHDOG_EN
        addRow("wdFire", 1, 1, t3, 0, 0, 0, PH_DISP, 0, 0, t3);
        addRow("wdFire", 1, 0, t3, 1, 0, 0, PH_RUN, 0, 0, t3);
        for (int i = 0; i < 7; i++) addRow("wdFire", 1, 0, t3, 0, 0, 0, PH_RUN, 0, 0, t3);
        addRow("wdFire", 1, 0, t3, 0, 0, 0, PH_FB, 0, 1, t3);
        addRow("wdFire", 1, 0, t3, 0, 0, 1, PH_IDLE, 1, 1, t3);
        addRow("wdSticky", 1, 0, t3, 0, 0, 0, PH_IDLE, 1, 1, t3);
        runTable();
        resetB();
        addRow("wdDoneWins", 1, 1, t4, 0, 0, 0, PH_DISP, 0, 0, t4);
        addRow("wdDoneWins", 1, 0, t4, 1, 0, 0, PH_RUN, 0, 0, t4);
        for (int i = 0; i < 7; i++) addRow("wdDoneWins", 1, 0, t4, 0, 0, 0, PH_RUN, 0, 0, t4);
        addRow("wdDoneWins", 1, 0, t4, 0, 1, 0, PH_FB, 0, 0, t4);
        addRow("wdDoneWins", 1, 0, t4, 0, 0, 1, PH_IDLE, 1, 0, t4);
        runTable();
`else
        addRow("noWd", 1, 1, t3, 0, 0, 0, PH_DISP, 0, 0, t3);
        addRow("noWd", 1, 0, t3, 1, 0, 0, PH_RUN, 0, 0, t3);
        for (int i = 0; i < 20; i++) addRow("noWd", 1, 0, t3, 0, 0, 0, PH_RUN, 0, 0, t3);
        addRow("noWd", 1, 0, t3, 0, 1, 0, PH_FB, 0, 0, t3);
        addRow("noWd", 1, 0, t3, 0, 0, 1, PH_IDLE, 1, 0, t3);
        runTable();
`endif

        // Two-bit completion counter wraps 1,2,3,0,1.
        resetB();
        for (int k = 1; k <= 5; k++) begin
            addRow("wrap", 1, 1, t4, 0, 0, 0, PH_DISP, (k - 1) % 4, 0, t4);
            addRow("wrap", 1, 0, t4, 1, 0, 0, PH_RUN, (k - 1) % 4, 0, t4);
            addRow("wrap", 1, 0, t4, 0, 1, 0, PH_FB, (k - 1) % 4, 0, t4);
            addRow("wrap", 1, 0, t4, 0, 0, 1, PH_IDLE, k % 4, 0, t4);
        end
        runTable();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hpu_task_frontend.md
HPU_TASK_FRONTEND -- requirements
Module: hpu_task_frontend

Interface
REQ-001 SHALL have parameter WATCHDOG_CYCLES, default 4096: maximum cycles in Running before forced completion (watchdog builds only).
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the completed-task counter.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all state on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port hpu_task_valid_i, input, 1 bit: task offered by the cluster scheduler.
REQ-006 SHALL have port hpu_task_ready_o, output, 1 bit: frontend can accept a task.
REQ-007 SHALL have port hpu_task_i, input, hpu_handler_task_t: task descriptor.
REQ-008 SHALL have port core_task_valid_o, output, 1 bit: latched task offered to the core.
REQ-009 SHALL have port core_task_ready_i, input, 1 bit: core takes the task.
REQ-010 SHALL have port core_task_o, output, hpu_handler_task_t: latched task.
REQ-011 SHALL have port core_done_i, input, 1 bit: single-cycle handler-completion pulse from the core.
REQ-012 SHALL have port hpu_feedback_valid_o, output, 1 bit: feedback offered to the cluster scheduler.
REQ-013 SHALL have port hpu_feedback_ready_i, input, 1 bit: feedback accepted.
REQ-014 SHALL have port hpu_feedback_o, output, task_feedback_descr_t: pkt_ptr plus feedback_descr.
REQ-015 SHALL have port hpu_active_o, output, 1 bit: frontend not Idle.
REQ-016 SHALL have port tasks_done_o, output, CNT_WIDTH bits: completed-task count.
REQ-017 SHALL have port wd_timeout_o, output, 1 bit: sticky watchdog-fired flag.

Function
REQ-018 SHALL implement the FSM states Idle, Dispatch, Running and Feedback, held in a register.
REQ-019 SHALL drive hpu_task_ready_o = (state == Idle), decoded from the registered state only.
REQ-020 SHALL, in Idle on hpu_task_valid_i && hpu_task_ready_o, latch hpu_task_i and enter Dispatch next cycle.
REQ-021 SHALL drive core_task_valid_o = (state == Dispatch), with core_task_o equal to the latched task and stable while valid.
REQ-022 SHALL, in Dispatch on core_task_ready_i, enter Running; otherwise it SHALL hold Dispatch indefinitely.
REQ-023 SHALL, in Running on core_done_i, enter Feedback next cycle.
REQ-024 SHALL ignore core_done_i outside Running, including a pulse coincident with the Dispatch handshake.
REQ-025 SHALL drive hpu_feedback_valid_o = (state == Feedback), with hpu_feedback_o stable while valid.
REQ-026 SHALL drive hpu_feedback_o.pkt_ptr from the latched pkt_ptr, and each hpu_feedback_o.feedback_descr field from the same-named field of the latched handler_task.
REQ-027 SHALL, in Feedback on hpu_feedback_ready_i, return to Idle and increment tasks_done_o by 1, wrapping modulo 2^CNT_WIDTH.
REQ-028 SHALL not accept a new task in the cycle it leaves Feedback; minimum task-to-task spacing is 4 cycles.
REQ-029 SHALL drive hpu_active_o = (state != Idle).

Reset
REQ-030 SHALL, on rst_i asserted at any time, immediately enter Idle, clear the latched task, tasks_done_o, the watchdog counter and wd_timeout_o, and drop all valid outputs to 0.
REQ-031 SHALL discard any in-flight task on reset mid-operation, with no feedback emitted for it.
REQ-032 SHALL present hpu_task_ready_o = 1 in the first cycle after rst_i deasserts.

Configuration
REQ-033 SHALL, with HPU_FRONTEND_WATCHDOG_EN defined, count cycles spent in Running from 0.
REQ-034 SHALL, in watchdog builds when the count reaches WATCHDOG_CYCLES-1 without core_done_i, enter Feedback and set wd_timeout_o until reset.
REQ-035 SHALL give core_done_i priority over the watchdog when both occur in the same cycle; wd_timeout_o is then not set.
REQ-036 SHALL, without HPU_FRONTEND_WATCHDOG_EN, omit the counter, tie wd_timeout_o to 0, and stay in Running until core_done_i.

Verification
REQ-037 SHALL cover basic flow: task pkt_ptr=0x1000_0040 accepted -> core_task_valid_o next cycle; core ready, done 10 cycles later, feedback ready immediately -> pkt_ptr=0x1000_0040 on feedback, tasks_done_o=1, ready again.
REQ-038 SHALL cover backpressure: hold core_task_ready_i=0 for 5 cycles, then hold hpu_feedback_ready_i=0 for 7 cycles -> outputs stable, hpu_task_ready_o=0, hpu_active_o=1 throughout.
REQ-039 SHALL cover a stray done: core_done_i pulsed in Idle and in the Dispatch handshake cycle -> no state change, no feedback, FSM waits in Running.
REQ-040 SHALL cover reset mid-task: rst_i asserted in Running -> next cycle all valids 0, tasks_done_o=0, hpu_task_ready_o=1 after deassert.
REQ-041 SHALL cover the watchdog (macro on, WATCHDOG_CYCLES=8): no core_done_i -> feedback after 8 Running cycles, wd_timeout_o=1; done in cycle 8 -> wd_timeout_o=0.
REQ-042 SHALL cover counter wrap: CNT_WIDTH=2, 5 tasks -> tasks_done_o reads 1,2,3,0,1.
